// File: rtl/rv_bp_pkg.sv
// Shared types and constants for the branch predictor BTB.
package rv_bp_pkg;

    localparam int unsigned BTB_ENTRIES_DEFAULT = 16;

    // 2-bit saturating counter encoding; MSB set means predict taken.
    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    // Tag is stored zero-extended to 32 bits so the struct is independent of table depth.
    typedef struct packed {
        logic        valid;
        logic [31:0] tag;
        logic [31:0] target;
        logic [1:0]  ctr;
    } btb_entry_t;

endpackage

// File: rtl/bp_sat_ctr.sv
// 2-bit saturating up/down counter next-state logic.
module bp_sat_ctr
    import rv_bp_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] ctr_next
);

    // Step toward ST on taken, toward SNT on not taken, holding at the rails.
    always_comb begin
        ctr_next = ctr;
        if (taken) begin
            if (ctr != ST) ctr_next = ctr + 2'd1;
        end else begin
            if (ctr != SNT) ctr_next = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters, EX-stage mispredict detection and perf counters.
module branch_predictor
    import rv_bp_pkg::*;
#(
    parameter int unsigned BTB_ENTRIES = BTB_ENTRIES_DEFAULT,
    parameter logic [1:0]  CTR_INIT    = WNT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC_F,
    output logic        sel,
    output logic [31:0] predicted_address,
    input  logic        ex_valid,
    input  logic        ex_is_branch,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        flag,
    output logic [31:0] PCback,
    output logic [31:0] branch_cnt,
    output logic [31:0] mispred_cnt
);

    localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);

    btb_entry_t r_btb [BTB_ENTRIES];
    logic [31:0] r_branch_cnt;
    logic [31:0] r_mispred_cnt;

    logic [IDX_W-1:0] w_f_idx;
    logic [31:0]      w_f_tag;
    logic             w_f_hit;
    logic [IDX_W-1:0] w_ex_idx;
    logic [31:0]      w_ex_tag;
    logic             w_ex_hit;
    logic             w_is_br;
    logic             w_bad_jump;
    logic             w_br_mis;
    logic [31:0]      w_ex_pc4;
    logic [1:0]       w_ctr_next;

    // Fetch-side lookup; reads pre-edge table contents only.
    always_comb begin
        w_f_idx           = PC_F[IDX_W+1:2];
        w_f_tag           = PC_F >> (IDX_W + 2);
        w_f_hit           = r_btb[w_f_idx].valid && (r_btb[w_f_idx].tag == w_f_tag);
        sel               = w_f_hit && r_btb[w_f_idx].ctr[1];
        predicted_address = sel ? r_btb[w_f_idx].target : 32'd0;
    end

    // EX-side resolution: detect mispredicts and pick the redirect PC.
    always_comb begin
        w_ex_idx   = ex_pc[IDX_W+1:2];
        w_ex_tag   = ex_pc >> (IDX_W + 2);
        w_ex_hit   = r_btb[w_ex_idx].valid && (r_btb[w_ex_idx].tag == w_ex_tag);
        w_ex_pc4   = ex_pc + 32'd4;
        w_is_br    = ex_valid && ex_is_branch;
        // A non-branch that fetch steered as taken was a stale BTB hit.
        w_bad_jump = ex_valid && !ex_is_branch && ex_pred_taken;
        w_br_mis   = w_is_br && ((ex_pred_taken != ex_taken) ||
                                 (ex_pred_taken && ex_taken && (ex_pred_target != ex_target)));
        flag       = w_br_mis || w_bad_jump;
        PCback     = 32'd0;
        if (w_bad_jump) begin
            PCback = w_ex_pc4;
        end else if (w_br_mis) begin
            PCback = ex_taken ? ex_target : w_ex_pc4;
        end
    end

    bp_sat_ctr u_sat_ctr (
        .ctr      (r_btb[w_ex_idx].ctr),
        .taken    (ex_taken),
        .ctr_next (w_ctr_next)
    );

    // Table training, invalidation and counter updates; reset suppresses any update.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
                r_btb[i] <= '{valid: 1'b0, tag: 32'd0, target: 32'd0, ctr: CTR_INIT};
            end
            r_branch_cnt  <= 32'd0;
            r_mispred_cnt <= 32'd0;
        end else begin
            if (w_is_br) begin
                if (w_ex_hit) begin
                    r_btb[w_ex_idx].ctr <= w_ctr_next;
                    if (ex_taken) r_btb[w_ex_idx].target <= ex_target;
                end else if (ex_taken) begin
                    r_btb[w_ex_idx] <= '{valid: 1'b1, tag: w_ex_tag, target: ex_target, ctr: WT};
                end
            end else if (w_bad_jump) begin
                r_btb[w_ex_idx].valid <= 1'b0;
                r_btb[w_ex_idx].ctr   <= CTR_INIT;
            end
            if (w_is_br && (r_branch_cnt != 32'hFFFF_FFFF)) begin
                r_branch_cnt <= r_branch_cnt + 32'd1;
            end
            if (flag && (r_mispred_cnt != 32'hFFFF_FFFF)) begin
                r_mispred_cnt <= r_mispred_cnt + 32'd1;
            end
        end
    end

    assign branch_cnt  = r_branch_cnt;
    assign mispred_cnt = r_mispred_cnt;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench: stimulus pushes expected outputs, a negedge monitor pops and compares.
module tb_branch_predictor;

    logic        clk;
    logic        rst;
    logic [31:0] PC_F;
    logic        sel;
    logic [31:0] predicted_address;
    logic        ex_valid;
    logic        ex_is_branch;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        flag;
    logic [31:0] PCback;
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;

    branch_predictor dut (
        .clk               (clk),
        .rst               (rst),
        .PC_F              (PC_F),
        .sel               (sel),
        .predicted_address (predicted_address),
        .ex_valid          (ex_valid),
        .ex_is_branch      (ex_is_branch),
        .ex_pc             (ex_pc),
        .ex_taken          (ex_taken),
        .ex_target         (ex_target),
        .ex_pred_taken     (ex_pred_taken),
        .ex_pred_target    (ex_pred_target),
        .flag              (flag),
        .PCback            (PCback),
        .branch_cnt        (branch_cnt),
        .mispred_cnt       (mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        sel;
        logic [31:0] pa;
        logic        flag;
        logic [31:0] pcb;
        logic [31:0] bc;
        logic [31:0] mc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Monitor: one expectation is consumed per cycle, away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (sel !== e.sel || predicted_address !== e.pa || flag !== e.flag ||
                PCback !== e.pcb || branch_cnt !== e.bc || mispred_cnt !== e.mc) begin
                errors++;
                $display("FAIL %s: got sel=%0b pa=%h flag=%0b pcb=%h bc=%0d mc=%0d, want sel=%0b pa=%h flag=%0b pcb=%h bc=%0d mc=%0d",
                         e.name, sel, predicted_address, flag, PCback, branch_cnt, mispred_cnt,
                         e.sel, e.pa, e.flag, e.pcb, e.bc, e.mc);
            end
        end
    end

    task automatic idle_ex();
        ex_valid       = 1'b0;
        ex_is_branch   = 1'b0;
        ex_pc          = 32'd0;
        ex_taken       = 1'b0;
        ex_target      = 32'd0;
        ex_pred_taken  = 1'b0;
        ex_pred_target = 32'd0;
    endtask

    // One cycle of stimulus plus its hand-computed expectation.
    task automatic step(input string nm, input logic [31:0] pcf,
                        input logic v, input logic br, input logic [31:0] epc,
                        input logic tk, input logic [31:0] tgt,
                        input logic pt, input logic [31:0] ptgt,
                        input logic e_sel, input logic [31:0] e_pa,
                        input logic e_flag, input logic [31:0] e_pcb,
                        input logic [31:0] e_bc, input logic [31:0] e_mc);
        exp_t e;
        @(posedge clk);
        #1;
        PC_F           = pcf;
        ex_valid       = v;
        ex_is_branch   = br;
        ex_pc          = epc;
        ex_taken       = tk;
        ex_target      = tgt;
        ex_pred_taken  = pt;
        ex_pred_target = ptgt;
        e.name = nm; e.sel = e_sel; e.pa = e_pa; e.flag = e_flag;
        e.pcb = e_pcb; e.bc = e_bc; e.mc = e_mc;
        sb.push_back(e);
    endtask

    initial begin
        int budget;
        rst  = 1'b1;
        PC_F = 32'd0;
        idle_ex();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        //    name            PC_F   v  br ex_pc  tk tgt   pt ptgt   sel pa     flg pcb     bc mc
        step("reset_lookup",  'h100, 0, 0, 'h0,   0, 'h0,  0, 'h0,   0, 'h0,   0, 'h0,   0, 0);
        step("alloc_taken",   'h100, 1, 1, 'h100, 1, 'h200,0, 'h0,   0, 'h0,   1, 'h200, 0, 0);
        step("hit_after",     'h100, 0, 0, 'h0,   0, 'h0,  0, 'h0,   1, 'h200, 0, 'h0,   1, 1);
        step("nt_mispred",    'h100, 1, 1, 'h100, 0, 'h200,1, 'h200, 1, 'h200, 1, 'h104, 1, 1);
        step("weak_nt_look",  'h100, 0, 0, 'h0,   0, 'h0,  0, 'h0,   0, 'h0,   0, 'h0,   2, 2);
        step("taken1_mis",    'h100, 1, 1, 'h100, 1, 'h200,0, 'h0,   0, 'h0,   1, 'h200, 2, 2);
        step("taken2_ok",     'h100, 1, 1, 'h100, 1, 'h200,1, 'h200, 1, 'h200, 0, 'h0,   3, 3);
        step("taken3_ok",     'h100, 1, 1, 'h100, 1, 'h200,1, 'h200, 1, 'h200, 0, 'h0,   4, 3);
        step("taken4_ok",     'h100, 1, 1, 'h100, 1, 'h200,1, 'h200, 1, 'h200, 0, 'h0,   5, 3);
        step("sat_nt_mis",    'h100, 1, 1, 'h100, 0, 'h200,1, 'h200, 1, 'h200, 1, 'h104, 6, 3);
        step("still_taken",   'h100, 0, 0, 'h0,   0, 'h0,  0, 'h0,   1, 'h200, 0, 'h0,   7, 4);
        step("tgt_mis_same",  'h100, 1, 1, 'h100, 1, 'h300,1, 'h200, 1, 'h200, 1, 'h300, 7, 4);
        step("new_target",    'h100, 0, 0, 'h0,   0, 'h0,  0, 'h0,   1, 'h300, 0, 'h0,   8, 5);
        step("nonbr_jump",    'h100, 1, 0, 'h140, 0, 'h0,  1, 'h300, 1, 'h300, 1, 'h144, 8, 5);
        step("invalidated",   'h100, 0, 0, 'h0,   0, 'h0,  0, 'h0,   0, 'h0,   0, 'h0,   8, 6);
        step("ex_invalid",    'h100, 0, 1, 'h100, 0, 'h0,  1, 'h200, 0, 'h0,   0, 'h0,   8, 6);
        step("nonbr_nopred",  'h100, 1, 0, 'h100, 1, 'h80, 0, 'h0,   0, 'h0,   0, 'h0,   8, 6);
        step("miss_nt_br",    'h100, 1, 1, 'h180, 0, 'h0,  0, 'h0,   0, 'h0,   0, 'h0,   8, 6);
        step("miss_nt_noalc", 'h180, 0, 0, 'h0,   0, 'h0,  0, 'h0,   0, 'h0,   0, 'h0,   9, 6);
        step("alloc_idx1",    'h180, 1, 1, 'h104, 1, 'h40, 0, 'h0,   0, 'h0,   1, 'h40,  9, 6);
        step("idx1_hit",      'h104, 0, 0, 'h0,   0, 'h0,  0, 'h0,   1, 'h40,  0, 'h0,  10, 7);
        step("idx1_tag_miss", 'h144, 0, 0, 'h0,   0, 'h0,  0, 'h0,   0, 'h0,   0, 'h0,  10, 7);
        step("low_bits_ign",  'h106, 0, 0, 'h0,   0, 'h0,  0, 'h0,   1, 'h40,  0, 'h0,  10, 7);
        step("pc4_wrap",      'h106, 1, 1, 'hFFFF_FFFC, 0, 'h0, 1, 'h8, 1, 'h40, 1, 'h0, 10, 7);
        step("cnt_after",     'h0,   0, 0, 'h0,   0, 'h0,  0, 'h0,   0, 'h0,   0, 'h0,  11, 8);

        // Mid-run reset with a taken branch presented that must not be learned.
        @(posedge clk);
        #1;
        rst            = 1'b1;
        ex_valid       = 1'b1;
        ex_is_branch   = 1'b1;
        ex_pc          = 32'h200;
        ex_taken       = 1'b1;
        ex_target      = 32'h400;
        ex_pred_taken  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_ex();

        step("rst_clr_idx1",  'h104, 0, 0, 'h0,   0, 'h0,  0, 'h0,   0, 'h0,   0, 'h0,   0, 0);
        step("rst_no_update", 'h200, 0, 0, 'h0,   0, 'h0,  0, 'h0,   0, 'h0,   0, 'h0,   0, 0);

        budget = 20;
        while (sb.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        if (sb.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d expectations left unconsumed, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
